// File: rtl/pry_scan_ser_pkg.sv
// Shared constants for the priority scan/serialise slice.
package pry_scan_ser_pkg;

  localparam int unsigned PRY_IMPL_LOOP  = 0;
  localparam int unsigned PRY_IMPL_ARITH = 1;

  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pry_scan_ser_oht2bin.sv
// One-hot to binary encoder built from OR-reductions; vld flags a non-zero input.
module oht2bin
  import pry_scan_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WIDTH_LOG = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] bin,
  output logic                 vld
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (oht[i]) begin
        bin = bin | WIDTH_LOG'(i);
      end
    end
  end

  assign vld = |oht;

endmodule

// File: rtl/pry_scan_ser_pry2oht.sv
// Priority-to-one-hot: isolates the first set bit, scanning from the LSB or MSB side.
module pry2oht
  import pry_scan_ser_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter              DIRECTION      = "LSB",
  parameter int unsigned IMPLEMENTATION = PRY_IMPL_LOOP
) (
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht
);

  localparam bit FROM_MSB = (DIRECTION == "MSB");

  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] one;

  // MSB-first is handled by mirroring into an LSB-first search and back.
  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      vec[i] = FROM_MSB ? pry[WIDTH-1-i] : pry[i];
    end
  end

  generate
    if (IMPLEMENTATION == PRY_IMPL_ARITH) begin : g_arith
      assign one = vec & (~vec + WIDTH'(1));
    end else begin : g_loop
      logic found;
      always_comb begin
        one   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (vec[i] && !found) begin
            one[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    oht = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      oht[i] = FROM_MSB ? one[WIDTH-1-i] : one[i];
    end
  end

endmodule

// File: rtl/pry_scan_ser.sv
// Serialises a request vector into one beat per set bit, in priority order,
// with one-hot and binary index per beat.
module pry_scan_ser
  import pry_scan_ser_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter              DIRECTION      = "LSB",
  parameter int unsigned IMPLEMENTATION = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         s_vld,
  output logic                         s_rdy,
  input  logic [WIDTH-1:0]             s_dat,
  output logic                         m_vld,
  input  logic                         m_rdy,
  output logic [WIDTH-1:0]             m_oht,
  output logic [$clog2(WIDTH)-1:0]     m_idx,
  output logic                         m_lst
);

  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] oht;
  logic [WIDTH_LOG-1:0] idx;
  logic             any_bit;
  logic             lst;
  logic             scan;

  pry2oht #(
    .WIDTH          (WIDTH),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_pry2oht (
    .pry (res),
    .oht (oht)
  );

  oht2bin #(
    .WIDTH     (WIDTH),
    .WIDTH_LOG (WIDTH_LOG)
  ) u_oht2bin (
    .oht (oht),
    .bin (idx),
    .vld (any_bit)
  );

  assign lst  = (res & ~oht) == '0;
  assign scan = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
    end else if (clr) begin
      state <= IDLE;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An all-zero vector is consumed without producing a beat.
          if (s_vld && (s_dat != '0)) begin
            res   <= s_dat;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (m_rdy) begin
            if (lst) begin
              res   <= '0;
              state <= IDLE;
            end else begin
              res <= res & ~oht;
            end
          end
        end
        default: begin
          state <= IDLE;
          res   <= '0;
        end
      endcase
    end
  end

  // Outputs depend only on state and residue; m_vld also requires a pending bit.
  assign s_rdy = ~scan;
  assign m_vld = scan & any_bit;
  assign m_oht = scan ? oht : '0;
  assign m_idx = scan ? idx : '0;
  assign m_lst = scan & lst;

endmodule

// File: tb/tb_pry_scan_ser.sv
// Bench for pry_scan_ser: LSB and MSB instances against a behavioural model,
// directed scenarios plus randomized traffic.
module tb_pry_scan_ser;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic s_vld = 1'b0;
  logic [W-1:0] s_dat = '0;
  logic m_rdy = 1'b0;

  logic         s_rdy_w [2];
  logic         m_vld_w [2];
  logic [W-1:0] m_oht_w [2];
  logic [2:0]   m_idx_w [2];
  logic         m_lst_w [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pry_scan_ser #(.WIDTH(W), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_vld(s_vld), .s_rdy(s_rdy_w[0]), .s_dat(s_dat),
    .m_vld(m_vld_w[0]), .m_rdy(m_rdy), .m_oht(m_oht_w[0]),
    .m_idx(m_idx_w[0]), .m_lst(m_lst_w[0])
  );

  pry_scan_ser #(.WIDTH(W), .DIRECTION("MSB"), .IMPLEMENTATION(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_vld(s_vld), .s_rdy(s_rdy_w[1]), .s_dat(s_dat),
    .m_vld(m_vld_w[1]), .m_rdy(m_rdy), .m_oht(m_oht_w[1]),
    .m_idx(m_idx_w[1]), .m_lst(m_lst_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of the next bit to emit: lowest for LSB order, highest for MSB.
  function automatic int pick(input logic [W-1:0] r, input int d);
    if (d == 0) begin
      for (int i = 0; i < W; i++) if (r[i]) return i;
    end else begin
      for (int i = W - 1; i >= 0; i--) if (r[i]) return i;
    end
    return 0;
  endfunction

  // Behavioural model: a busy flag and the remaining bits for each order.
  bit           busy = 1'b0;
  logic [W-1:0] mres [2] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      busy = 1'b0;
      mres[0] = '0;
      mres[1] = '0;
    end else if (!busy) begin
      if (s_vld && s_dat != '0) begin
        busy = 1'b1;
        mres[0] = s_dat;
        mres[1] = s_dat;
      end
    end else if (m_rdy) begin
      for (int d = 0; d < 2; d++) mres[d][pick(mres[d], d)] = 1'b0;
      busy = (mres[0] != '0);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int           k;
      logic [W-1:0] eo;
      k  = pick(mres[d], d);
      eo = busy ? (W'(1) << k) : '0;
      chk($sformatf("s_rdy[%0d]", d), 32'(s_rdy_w[d]), 32'(!busy));
      chk($sformatf("m_vld[%0d]", d), 32'(m_vld_w[d]), 32'(busy));
      chk($sformatf("m_oht[%0d]", d), 32'(m_oht_w[d]), 32'(eo));
      chk($sformatf("m_idx[%0d]", d), 32'(m_idx_w[d]), busy ? 32'(k) : 32'd0);
      chk($sformatf("m_lst[%0d]", d), 32'(m_lst_w[d]),
          32'(busy && ($countones(mres[d]) == 1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int           lidx [3];
    int           midx [3];
    logic [W-1:0] moht [3];
    logic [3:0]   pat;
    int           q [$];

    lidx = '{2, 5, 7};
    midx = '{7, 5, 2};
    moht = '{8'h80, 8'h20, 8'h04};
    pat  = 4'b1001;

    #2;
    chk("reset_s_rdy", 32'(s_rdy_w[0]), 32'd1);
    chk("reset_m_vld", 32'(m_vld_w[0]), 32'd0);
    chk("reset_m_oht", 32'(m_oht_w[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Vector 1010_0100 streamed with m_rdy held high.
    s_vld = 1'b1; s_dat = 8'hA4; m_rdy = 1'b1;
    tick();
    s_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("a4_lsb_idx", 32'(m_idx_w[0]), 32'(lidx[i]));
      chk("a4_lsb_lst", 32'(m_lst_w[0]), 32'(i == 2));
      chk("a4_msb_idx", 32'(m_idx_w[1]), 32'(midx[i]));
      chk("a4_msb_oht", 32'(m_oht_w[1]), 32'(moht[i]));
      chk("a4_msb_lst", 32'(m_lst_w[1]), 32'(i == 2));
      tick();
    end
    chk("a4_s_rdy_after", 32'(s_rdy_w[0]), 32'd1);
    chk("a4_m_vld_after", 32'(m_vld_w[0]), 32'd0);

    // Zero vector is accepted and dropped.
    s_vld = 1'b1; s_dat = 8'h00;
    chk("zero_s_rdy", 32'(s_rdy_w[0]), 32'd1);
    tick();
    s_vld = 1'b0;
    chk("zero_m_vld", 32'(m_vld_w[0]), 32'd0);
    chk("zero_s_rdy_after", 32'(s_rdy_w[0]), 32'd1);
    tick();

    // All ones with m_rdy pattern 1,0,0,1 repeating.
    s_vld = 1'b1; s_dat = 8'hFF;
    tick();
    s_vld = 1'b0;
    for (int k = 0; k < 40 && q.size() < 8; k++) begin
      m_rdy = pat[k % 4];
      @(negedge clk);
      if (m_vld_w[0] && m_rdy) q.push_back(int'(m_idx_w[0]));
      tick();
    end
    chk("ff_beats", 32'(q.size()), 32'd8);
    for (int i = 0; i < q.size(); i++) chk("ff_order", 32'(q[i]), 32'(i));
    chk("ff_s_rdy_after", 32'(s_rdy_w[0]), 32'd1);
    m_rdy = 1'b1;
    tick();

    // clr during first beat of 0011_0000.
    s_vld = 1'b1; s_dat = 8'h30;
    tick();
    s_vld = 1'b0;
    chk("clr_first_idx", 32'(m_idx_w[0]), 32'd4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_m_vld", 32'(m_vld_w[0]), 32'd0);
    chk("clr_s_rdy", 32'(s_rdy_w[0]), 32'd1);
    tick();
    chk("clr_no_idx5", 32'(m_vld_w[0]), 32'd0);

    // Asynchronous reset mid-scan with three bits pending.
    s_vld = 1'b1; s_dat = 8'h07; m_rdy = 1'b0;
    tick();
    s_vld = 1'b0;
    chk("rst_pre_vld", 32'(m_vld_w[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 32'(m_vld_w[0]), 32'd0);
    chk("rst_async_rdy", 32'(s_rdy_w[1]), 32'd1);
    chk("rst_async_oht", 32'(m_oht_w[1]), 32'd0);
    chk("rst_async_lst", 32'(m_lst_w[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    s_vld = 1'b1; s_dat = 8'h01; m_rdy = 1'b1;
    tick();
    s_vld = 1'b0;
    chk("post_rst_idx", 32'(m_idx_w[0]), 32'd0);
    chk("post_rst_lst", 32'(m_lst_w[0]), 32'd1);
    chk("post_rst_msb_lst", 32'(m_lst_w[1]), 32'd1);
    tick();
    chk("post_rst_done", 32'(m_vld_w[0]), 32'd0);

    // Single top bit.
    s_vld = 1'b1; s_dat = 8'h80;
    tick();
    s_vld = 1'b0;
    chk("top_idx", 32'(m_idx_w[0]), 32'd7);
    chk("top_lst", 32'(m_lst_w[0]), 32'd1);
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      s_vld = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       s_dat = '0;
        1:       s_dat = W'(1) << $urandom_range(0, W - 1);
        2:       s_dat = '1;
        default: s_dat = W'($urandom);
      endcase
      m_rdy = ($urandom_range(0, 9) < 7);
      clr   = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr = 1'b0; s_vld = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
